// File: rtl/operand_fetch.sv
// Operand-fetch stage: buffers one decoded instruction, waits out RAW/WAW hazards
// against a pending-write scoreboard, reads the register file once, and hands operands on.
module operand_fetch #(
  parameter int WORD_SIZE   = 32,
  parameter int SEL_WIDTH   = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SEL_WIDTH-1:0]          in_sel_a,
  input  logic [SEL_WIDTH-1:0]          in_sel_b,
  input  logic                          in_use_a,
  input  logic                          in_use_b,
  input  logic signed [COUNT_WIDTH-1:0] in_count_a,
  input  logic signed [COUNT_WIDTH-1:0] in_count_b,
  input  logic [SEL_WIDTH-1:0]          in_sel_dst,
  input  logic                          in_wr_dst,
  output logic [SEL_WIDTH-1:0]          rf_sel_a,
  output logic [SEL_WIDTH-1:0]          rf_sel_b,
  output logic                          rf_oe_a,
  output logic                          rf_oe_b,
  output logic signed [COUNT_WIDTH-1:0] rf_count_a,
  output logic signed [COUNT_WIDTH-1:0] rf_count_b,
  input  logic [WORD_SIZE-1:0]          rf_a,
  input  logic [WORD_SIZE-1:0]          rf_b,
  input  logic                          wb_valid,
  input  logic [SEL_WIDTH-1:0]          wb_sel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_SIZE-1:0]          out_a,
  output logic [WORD_SIZE-1:0]          out_b,
  output logic [SEL_WIDTH-1:0]          out_sel_dst,
  output logic                          out_wr_dst
);

  typedef enum logic [1:0] {IDLE, CHECK, OUT} state_t;

  state_t                          state;
  logic [SEL_WIDTH-1:0]            sel_a_p0, sel_b_p0, sel_dst_p0;
  logic                            use_a_p0, use_b_p0, wr_dst_p0;
  logic signed [COUNT_WIDTH-1:0]   count_a_p0, count_b_p0;
  logic [(2**SEL_WIDTH)-1:0]       pending, pending_next;
  logic                            hazard, issue, shared_src;

  assign hazard = (use_a_p0 & pending[sel_a_p0]) |
                  (use_b_p0 & pending[sel_b_p0]) |
                  (wr_dst_p0 & pending[sel_dst_p0]);
  assign issue      = (state == CHECK) && !hazard;
  assign shared_src = use_a_p0 && (sel_a_p0 == sel_b_p0);

  assign in_ready   = (state == IDLE);
  assign rf_sel_a   = sel_a_p0;
  assign rf_sel_b   = sel_b_p0;
  assign rf_oe_a    = issue & use_a_p0;
  assign rf_oe_b    = issue & use_b_p0;
  // A register read on both ports must only be bumped once, so port b yields
  assign rf_count_a = (issue && use_a_p0) ? count_a_p0 : '0;
  assign rf_count_b = (issue && use_b_p0 && !shared_src) ? count_b_p0 : '0;

  // Set beats clear: a result issued this edge is still outstanding afterwards
  always_comb begin
    pending_next = pending;
    if (wb_valid)
      pending_next[wb_sel] = 1'b0;
    if (issue && wr_dst_p0)
      pending_next[sel_dst_p0] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      sel_a_p0    <= '0;
      sel_b_p0    <= '0;
      sel_dst_p0  <= '0;
      use_a_p0    <= 1'b0;
      use_b_p0    <= 1'b0;
      wr_dst_p0   <= 1'b0;
      count_a_p0  <= '0;
      count_b_p0  <= '0;
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_sel_dst <= '0;
      out_wr_dst  <= 1'b0;
    end else begin
      pending <= pending_next;
      case (state)
        // p0: instruction buffer
        IDLE: begin
          if (in_valid) begin
            sel_a_p0   <= in_sel_a;
            sel_b_p0   <= in_sel_b;
            sel_dst_p0 <= in_sel_dst;
            use_a_p0   <= in_use_a;
            use_b_p0   <= in_use_b;
            wr_dst_p0  <= in_wr_dst;
            count_a_p0 <= in_count_a;
            count_b_p0 <= in_count_b;
            state      <= CHECK;
          end
        end
        // p1: operand capture at the issue edge (pre-increment values)
        CHECK: begin
          if (!hazard) begin
            out_a       <= use_a_p0 ? rf_a : '0;
            out_b       <= use_b_p0 ? rf_b : '0;
            out_sel_dst <= sel_dst_p0;
            out_wr_dst  <= wr_dst_p0;
            out_valid   <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model, transaction-level reference model,
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_sel_a = '0, in_sel_b = '0, in_sel_dst = '0;
  logic        in_use_a = 1'b0, in_use_b = 1'b0, in_wr_dst = 1'b0;
  logic [7:0]  in_count_a = '0, in_count_b = '0;
  logic [7:0]  rf_sel_a, rf_sel_b;
  logic        rf_oe_a, rf_oe_b;
  logic [7:0]  rf_count_a, rf_count_b;
  logic [31:0] rf_a, rf_b;
  logic        wb_valid = 1'b0;
  logic [7:0]  wb_sel = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a, out_b;
  logic [7:0]  out_sel_dst;
  logic        out_wr_dst;

  int n_checks = 0;
  int n_fail   = 0;
  int nz_a     = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel_a(in_sel_a), .in_sel_b(in_sel_b),
    .in_use_a(in_use_a), .in_use_b(in_use_b),
    .in_count_a(in_count_a), .in_count_b(in_count_b),
    .in_sel_dst(in_sel_dst), .in_wr_dst(in_wr_dst),
    .rf_sel_a(rf_sel_a), .rf_sel_b(rf_sel_b),
    .rf_oe_a(rf_oe_a), .rf_oe_b(rf_oe_b),
    .rf_count_a(rf_count_a), .rf_count_b(rf_count_b),
    .rf_a(rf_a), .rf_b(rf_b),
    .wb_valid(wb_valid), .wb_sel(wb_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_sel_dst(out_sel_dst), .out_wr_dst(out_wr_dst)
  );

  function automatic logic [31:0] sx(input logic [7:0] c);
    return {{24{c[7]}}, c};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register file: undriven read buses show garbage so unused operands must be zeroed
  logic [31:0] regs [256] = '{default: 32'h0};
  assign rf_a = rf_oe_a ? regs[rf_sel_a] : 32'hDEAD_BEEF;
  assign rf_b = rf_oe_b ? regs[rf_sel_b] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (wb_valid) regs[wb_sel] <= wb_data;
    if (rf_oe_a) regs[rf_sel_a] <= regs[rf_sel_a] + sx(rf_count_a);
    if (rf_oe_b) regs[rf_sel_b] <= regs[rf_sel_b] + sx(rf_count_b) +
                                   ((rf_oe_a && rf_sel_a == rf_sel_b) ? sx(rf_count_a) : 32'h0);
  end

  // Reference model: one held instruction, which is either waiting or presented
  bit          m_busy, m_iss;
  bit          m_ua, m_ub, m_wd;
  logic [7:0]  m_sa, m_sb, m_sd, m_ca, m_cb;
  bit          m_pend [256];
  logic [31:0] m_regs [256] = '{default: 32'h0};
  logic [31:0] e_a, e_b;
  logic [7:0]  e_sd;
  bit          e_wd;

  function automatic bit m_blocked();
    return (m_ua && m_pend[m_sa]) || (m_ub && m_pend[m_sb]) || (m_wd && m_pend[m_sd]);
  endfunction

  always @(posedge clk or posedge rst) begin
    bit go;
    if (rst) begin
      m_busy = 0; m_iss = 0; m_ua = 0; m_ub = 0; m_wd = 0;
      m_sa = 0; m_sb = 0; m_sd = 0; m_ca = 0; m_cb = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
      e_a = 0; e_b = 0; e_sd = 0; e_wd = 0;
    end else begin
      go = m_busy && !m_iss && !m_blocked();
      if (go) begin
        e_a  = m_ua ? m_regs[m_sa] : 32'h0;
        e_b  = m_ub ? m_regs[m_sb] : 32'h0;
        e_sd = m_sd;
        e_wd = m_wd;
      end
      if (wb_valid) begin
        m_regs[wb_sel] = wb_data;
        m_pend[wb_sel] = 0;
      end
      if (go) begin
        if (m_ua) m_regs[m_sa] = m_regs[m_sa] + sx(m_ca);
        if (m_ub && !(m_ua && m_sa == m_sb)) m_regs[m_sb] = m_regs[m_sb] + sx(m_cb);
        if (m_wd) m_pend[m_sd] = 1;
      end
      if (m_iss) begin
        if (out_ready) begin m_busy = 0; m_iss = 0; end
      end else if (go) begin
        m_iss = 1;
      end else if (!m_busy && in_valid) begin
        m_busy = 1;
        m_sa = in_sel_a; m_sb = in_sel_b; m_sd = in_sel_dst;
        m_ua = in_use_a; m_ub = in_use_b; m_wd = in_wr_dst;
        m_ca = in_count_a; m_cb = in_count_b;
      end
    end
  end

  int rot = 0;
  always @(negedge clk) begin
    bit iss;
    iss = m_busy && !m_iss && !m_blocked();
    if (rf_count_a != 0) nz_a++;
    chk("in_ready",   in_ready,   !m_busy);
    chk("out_valid",  out_valid,  m_iss);
    chk("rf_oe_a",    rf_oe_a,    iss && m_ua);
    chk("rf_oe_b",    rf_oe_b,    iss && m_ub);
    chk("rf_count_a", rf_count_a, (iss && m_ua) ? m_ca : 8'h0);
    chk("rf_count_b", rf_count_b, (iss && m_ub && !(m_ua && m_sa == m_sb)) ? m_cb : 8'h0);
    chk("rf_sel_a",   rf_sel_a,   m_sa);
    chk("rf_sel_b",   rf_sel_b,   m_sb);
    if (m_iss) begin
      chk("out_a",       out_a,       e_a);
      chk("out_b",       out_b,       e_b);
      chk("out_sel_dst", out_sel_dst, e_sd);
      chk("out_wr_dst",  out_wr_dst,  e_wd);
    end
    chk("regfile", regs[rot], m_regs[rot]);
    rot = (rot + 1) % 16;
  end

  // All drivers below run 1 time unit after a rising edge
  task automatic wb_write(input logic [7:0] s, input logic [31:0] d);
    wb_valid = 1; wb_sel = s; wb_data = d;
    @(posedge clk); #1;
    wb_valid = 0;
  endtask

  task automatic offer(input logic [7:0] sa, input bit ua, input logic [7:0] ca,
                       input logic [7:0] sb, input bit ub, input logic [7:0] cb,
                       input logic [7:0] sd, input bit wd);
    bit ok = 0;
    in_sel_a = sa; in_use_a = ua; in_count_a = ca;
    in_sel_b = sb; in_use_b = ub; in_count_b = cb;
    in_sel_dst = sd; in_wr_dst = wd; in_valid = 1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_out();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    if (!ok) chk("out_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    logic [31:0] hold_a, hold_b;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_rf_oe", {rf_oe_a, rf_oe_b}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Basic read, two-cycle latency, then backpressure
    wb_write(3, 32'h10);
    wb_write(4, 32'h20);
    offer(3, 1, 0, 4, 1, 0, 0, 0);
    @(negedge clk);
    chk("lat_issue_oe", {rf_oe_a, rf_oe_b}, 2'b11);
    chk("lat_not_yet", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("basic_a", out_a, 32'h10);
    chk("basic_b", out_b, 32'h20);
    hold_a = out_a; hold_b = out_b;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_a", out_a, hold_a);
      chk("bp_b", out_b, hold_b);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;

    // Post-decrement
    wb_write(5, 32'd7);
    n0 = nz_a;
    offer(5, 1, 8'hFF, 0, 0, 0, 0, 0);
    wait_out();
    chk("pinc_a", out_a, 32'd7);
    chk("pinc_b", out_b, 32'd0);
    chk("pinc_r5", regs[5], 32'd6);
    chk("pinc_once", nz_a - n0, 1);
    out_ready = 1;
    @(posedge clk); #1;

    // RAW hazard released by writeback
    offer(0, 0, 0, 0, 0, 0, 2, 1);
    repeat (3) @(posedge clk);
    #1 out_ready = 0;
    offer(2, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("raw_stall_oe", rf_oe_a, 0);
      chk("raw_stall_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    wb_write(2, 32'h55);
    @(negedge clk);
    chk("raw_issue_oe", rf_oe_a, 1);
    @(negedge clk);
    chk("raw_valid", out_valid, 1);
    chk("raw_a", out_a, 32'h55);
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;

    // Same register on both ports
    wb_write(9, 32'd100);
    offer(9, 1, 8'd2, 9, 1, 8'd3, 0, 0);
    wait_out();
    chk("same_a", out_a, 32'd100);
    chk("same_b", out_b, 32'd100);
    chk("same_r9", regs[9], 32'd102);
    out_ready = 1;
    @(posedge clk); #1;

    // Reset during a stall
    offer(0, 0, 0, 0, 0, 0, 6, 1);
    repeat (3) @(posedge clk);
    #1 out_ready = 0;
    offer(6, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_oe", {rf_oe_a, rf_oe_b}, 0);
    chk("mrst_cnt", {rf_count_a, rf_count_b}, 0);
    chk("mrst_sel", {rf_sel_a, rf_sel_b}, 0);
    chk("mrst_out", {out_a | out_b, 7'h0, out_wr_dst}, 0);
    @(posedge clk); #1 rst = 0;
    offer(6, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_no_stall", rf_oe_a, 1);
    @(posedge clk); #1 out_ready = 1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit rdy;
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (in_valid && rdy) in_valid = 0;
      if (!in_valid && ($urandom_range(0, 2) != 0)) begin
        in_valid = 1;
        in_sel_a = 8'($urandom_range(0, 7)); in_use_a = 1'($urandom);
        in_sel_b = 8'($urandom_range(0, 7)); in_use_b = 1'($urandom);
        in_count_a = 8'($urandom); in_count_b = 8'($urandom);
        in_sel_dst = 8'($urandom_range(0, 7)); in_wr_dst = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0) begin
        wb_sel = 8'($urandom_range(0, 7));
        wb_data = m_pend[wb_sel] ? $urandom : m_regs[wb_sel];
        wb_valid = 1;
      end else begin
        wb_valid = 0;
      end
    end
    in_valid = 0; wb_valid = 0;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
